// File: rtl/nios_qsys_file_pio_in.sv
// Avalon-MM input PIO: synchronized inputs, edge capture with
// write-one-to-clear, interrupt mask and registered read data.
module nios_qsys_file_pio_in #(
  parameter int WIDTH       = 25,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int ARM = SYNC_STAGES + 1;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_det;
  logic [2:0]       arm_cnt;
  logic             armed;
  logic             rd_en;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_ok;

  assign unused_ok = &{1'b0, writedata};

  assign rd_en = chipselect & ~read_n;
  assign wr_en = chipselect & ~write_n;
  assign data  = sync_q[SYNC_STAGES-1];
  assign armed = (arm_cnt == 3'(ARM));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      prev <= data;
    end
  end

  // Hold off detection until the chain has flushed reset-time levels.
  always_ff @(posedge clk) begin
    if (reset)
      arm_cnt <= '0;
    else if (!armed)
      arm_cnt <= arm_cnt + 3'd1;
  end

  always_comb begin
    edge_raw = '0;
    case (EDGE_TYPE)
      0:       edge_raw = data & ~prev;
      1:       edge_raw = ~data & prev;
      default: edge_raw = data ^ prev;
    endcase
    edge_det = armed ? edge_raw : '0;
  end

  // A new edge outranks a simultaneous clear of the same bit.
  always_ff @(posedge clk) begin
    if (reset)
      edgecap <= '0;
    else if (wr_en && address == 2'd3)
      edgecap <= (edgecap & ~writedata[WIDTH-1:0]) | edge_det;
    else
      edgecap <= edgecap | edge_det;
  end

  always_ff @(posedge clk) begin
    if (reset)
      irqmask <= '0;
    else if (wr_en && address == 2'd2)
      irqmask <= writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = data;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecap;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      readdata <= '0;
    else if (rd_en)
      readdata <= rd_mux;
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_nios_qsys_file_pio_in.sv
// Bench for nios_qsys_file_pio_in: rising-edge instance plus an
// any-edge instance, read results checked through a scoreboard queue.
module tb_nios_qsys_file_pio_in;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        cs0;
  logic        cs1;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [24:0] in0;
  logic [24:0] in1;
  logic [31:0] rd0;
  logic [31:0] rd1;
  logic        irq0;
  logic        irq1;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_q [$];
  string       name_q [$];

  always #5 clk = ~clk;

  nios_qsys_file_pio_in #(
    .WIDTH(25), .EDGE_TYPE(0), .SYNC_STAGES(2)
  ) u_rise (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(cs0), .read_n(read_n), .write_n(write_n),
    .writedata(writedata), .in_port(in0),
    .readdata(rd0), .irq(irq0)
  );

  nios_qsys_file_pio_in #(
    .WIDTH(25), .EDGE_TYPE(2), .SYNC_STAGES(2)
  ) u_any (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(cs1), .read_n(read_n), .write_n(write_n),
    .writedata(writedata), .in_port(in1),
    .readdata(rd1), .irq(irq1)
  );

  task automatic cycle(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_check(input int dev);
    logic [31:0] got;
    logic [31:0] want;
    string       nm;
    got = (dev == 1) ? rd1 : rd0;
    vectors++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: readdata=%h expected none", got);
    end else begin
      want = exp_q.pop_front();
      nm   = name_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL %s: readdata=%h expected %h", nm, got, want);
      end
    end
  endtask

  task automatic bus_write(input int dev, input logic [1:0] a,
                           input logic [31:0] d);
    cs0 = (dev == 0);
    cs1 = (dev == 1);
    address = a;
    writedata = d;
    write_n = 1'b0;
    cycle();
    cs0 = 1'b0;
    cs1 = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic bus_read(input int dev, input logic [1:0] a,
                          input logic [31:0] exp, input string nm);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    cs0 = (dev == 0);
    cs1 = (dev == 1);
    address = a;
    read_n = 1'b0;
    cycle();
    cs0 = 1'b0;
    cs1 = 1'b0;
    read_n = 1'b1;
    sb_check(dev);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cycle(3);
    vectors++;
    if (rd0 !== 32'h0) begin
      errors++;
      $display("FAIL rst_rd: readdata=%h expected 0", rd0);
    end
    vectors++;
    if (irq0 !== 1'b0 || irq1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_irq: irq=%b%b expected 00", irq0, irq1);
    end
    reset = 1'b0;
    cycle(4);
    bus_read(0, 2'd0, 32'h0, "rst_data");
    bus_read(0, 2'd2, 32'h0, "rst_mask");
    bus_read(0, 2'd3, 32'h0, "rst_ec");
    bus_read(1, 2'd3, 32'h0, "rst_ec_any");
  endtask

  task automatic test_rising;
    bus_write(0, 2'd2, 32'h1);
    in0[0] = 1'b1;
    cycle(2);
    vectors++;
    if (irq0 !== 1'b0) begin
      errors++;
      $display("FAIL rise_early: irq=%b expected 0", irq0);
    end
    cycle(1);
    vectors++;
    if (irq0 !== 1'b1) begin
      errors++;
      $display("FAIL rise_latency: irq=%b expected 1", irq0);
    end
    bus_read(0, 2'd3, 32'h1, "rise_ec");
    bus_read(0, 2'd0, 32'h1, "rise_data");
  endtask

  task automatic test_clear;
    in0[2] = 1'b1;
    cycle(4);
    bus_read(0, 2'd3, 32'h5, "clr_pre");
    bus_write(0, 2'd2, 32'h4);
    bus_write(0, 2'd3, 32'h1);
    bus_read(0, 2'd3, 32'h4, "clr_bit0");
    vectors++;
    if (irq0 !== 1'b1) begin
      errors++;
      $display("FAIL clr_irq: irq=%b expected 1", irq0);
    end
    bus_write(0, 2'd3, 32'h4);
    vectors++;
    if (irq0 !== 1'b0) begin
      errors++;
      $display("FAIL clr_irq_off: irq=%b expected 0", irq0);
    end
    bus_read(0, 2'd3, 32'h0, "clr_all");
  endtask

  task automatic test_collision;
    bus_write(0, 2'd2, 32'h1);
    in0[0] = 1'b0;
    cycle(4);
    bus_read(0, 2'd3, 32'h0, "fall_ignored");
    in0[0] = 1'b1;
    cycle(4);
    vectors++;
    if (irq0 !== 1'b1) begin
      errors++;
      $display("FAIL coll_pre: irq=%b expected 1", irq0);
    end
    in0[0] = 1'b0;
    cycle(4);
    in0[0] = 1'b1;
    cycle(2);
    bus_write(0, 2'd3, 32'h1);
    vectors++;
    if (irq0 !== 1'b1) begin
      errors++;
      $display("FAIL coll_irq: irq=%b expected 1", irq0);
    end
    bus_read(0, 2'd3, 32'h1, "coll_ec");
    bus_write(0, 2'd3, 32'h1);
    bus_read(0, 2'd3, 32'h0, "coll_after");
    vectors++;
    if (irq0 !== 1'b0) begin
      errors++;
      $display("FAIL coll_clr_irq: irq=%b expected 0", irq0);
    end
  endtask

  task automatic test_mask;
    in0[1] = 1'b1;
    cycle(4);
    vectors++;
    if (irq0 !== 1'b0) begin
      errors++;
      $display("FAIL mask_off: irq=%b expected 0", irq0);
    end
    bus_read(0, 2'd3, 32'h2, "mask_ec");
    bus_write(0, 2'd2, 32'h2);
    vectors++;
    if (irq0 !== 1'b1) begin
      errors++;
      $display("FAIL mask_on: irq=%b expected 1", irq0);
    end
    bus_read(0, 2'd1, 32'h0, "rsvd");
    bus_write(0, 2'd1, 32'hFFFF_FFFF);
    bus_read(0, 2'd1, 32'h0, "rsvd_wr");
    bus_write(0, 2'd0, 32'h0);
    bus_read(0, 2'd0, 32'h7, "data_ro");
  endtask

  task automatic test_back_to_back;
    exp_q.push_back(32'h2);
    name_q.push_back("rw_same");
    cs0 = 1'b1;
    address = 2'd2;
    writedata = 32'hFFFF_FFFF;
    read_n = 1'b0;
    write_n = 1'b0;
    cycle();
    cs0 = 1'b0;
    read_n = 1'b1;
    write_n = 1'b1;
    sb_check(0);
    bus_read(0, 2'd2, 32'h01FF_FFFF, "mask_msb");
    bus_write(0, 2'd3, 32'hFFFF_FFFF);
    vectors++;
    if (irq0 !== 1'b0) begin
      errors++;
      $display("FAIL clr_wide: irq=%b expected 0", irq0);
    end
  endtask

  task automatic test_any_edge;
    bus_write(1, 2'd2, 32'h8);
    in1[3] = 1'b1;
    cycle(2);
    vectors++;
    if (irq1 !== 1'b0) begin
      errors++;
      $display("FAIL any_early: irq=%b expected 0", irq1);
    end
    cycle(1);
    vectors++;
    if (irq1 !== 1'b1) begin
      errors++;
      $display("FAIL any_rise: irq=%b expected 1", irq1);
    end
    bus_read(1, 2'd3, 32'h8, "any_rise_ec");
    bus_write(1, 2'd3, 32'h8);
    bus_read(1, 2'd3, 32'h0, "any_clr");
    in1[3] = 1'b0;
    cycle(3);
    vectors++;
    if (irq1 !== 1'b1) begin
      errors++;
      $display("FAIL any_fall: irq=%b expected 1", irq1);
    end
    bus_read(1, 2'd3, 32'h8, "any_fall_ec");
  endtask

  task automatic test_reset_high;
    bus_write(0, 2'd2, 32'h1);
    in0 = '1;
    in1 = '1;
    cycle(1);
    reset = 1'b1;
    cycle(2);
    vectors++;
    if (rd0 !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_rd: readdata=%h expected 0", rd0);
    end
    vectors++;
    if (irq1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_irq: irq=%b expected 0", irq1);
    end
    reset = 1'b0;
    cycle(6);
    bus_write(0, 2'd2, 32'h01FF_FFFF);
    bus_write(1, 2'd2, 32'h01FF_FFFF);
    vectors++;
    if (irq0 !== 1'b0 || irq1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_spur: irq=%b%b expected 00", irq0, irq1);
    end
    bus_read(0, 2'd3, 32'h0, "rst_hi_ec");
    bus_read(1, 2'd3, 32'h0, "rst_hi_ec_any");
    bus_read(0, 2'd0, 32'h01FF_FFFF, "rst_hi_data");
    in0[24] = 1'b0;
    cycle(4);
    bus_read(0, 2'd3, 32'h0, "msb_fall");
    in0[24] = 1'b1;
    cycle(4);
    bus_read(0, 2'd3, 32'h0100_0000, "msb_rise");
    vectors++;
    if (irq0 !== 1'b1) begin
      errors++;
      $display("FAIL msb_irq: irq=%b expected 1", irq0);
    end
  endtask

  initial begin
    reset = 1'b1;
    address = 2'd0;
    cs0 = 1'b0;
    cs1 = 1'b0;
    read_n = 1'b1;
    write_n = 1'b1;
    writedata = 32'h0;
    in0 = '0;
    in1 = '0;
    test_reset();
    test_rising();
    test_clear();
    test_collision();
    test_mask();
    test_back_to_back();
    test_any_edge();
    test_reset_high();
    cycle(2);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: pending=%0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t expected finish earlier", $time);
    $fatal(1);
  end

endmodule

// File: doc/nios_qsys_file_pio_in.md
NIOS_QSYS_FILE_PIO_IN -- requirements
Module: nios_qsys_file_pio_in

Interface
REQ-001 Parameter WIDTH, default 25, width of in_port and all per-bit registers (1..32).
REQ-002 Parameter EDGE_TYPE, default 0, edge-capture type: 0 rising, 1 falling, 2 any.
REQ-003 Parameter SYNC_STAGES, default 2, input synchronizer depth (2..4).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 address  input  2  Avalon-MM slave word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 read_n  input  1  active-low read strobe.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 in_port  input  WIDTH  asynchronous external inputs.
REQ-012 readdata  output  32  registered read data.
REQ-013 irq  output  1  level interrupt request.

Function
REQ-014 Register map: 0 data (RO), 1 reserved (reads 0, writes ignored), 2 irqmask (RW), 3 edgecapture (RW1C).
REQ-015 in_port passes through a SYNC_STAGES-deep flop chain; data register = last stage output.
REQ-016 Change on in_port set up before edge k appears in data after edge k+SYNC_STAGES-1.
REQ-017 prev register holds the previous data value each cycle; edge bit i = rising (data&~prev), falling (~data&prev), or any (data^prev) per EDGE_TYPE.
REQ-018 Detected edge sets edgecapture bit on the edge after data changes; bit stays set until cleared.
REQ-019 Write (chipselect & ~write_n) to address 3 clears each edgecapture bit whose writedata bit is 1; 0 bits unaffected.
REQ-020 Clear and new edge on same bit in same cycle: edge wins, bit remains 1.
REQ-021 Write to address 2 loads irqmask <= writedata[WIDTH-1:0]; writes to 0 and 1 ignored.
REQ-022 irq = OR over (edgecapture & irqmask), combinational from registers, no extra latency.
REQ-023 Read accepted when chipselect & ~read_n; readdata updated on that edge, valid next cycle (read latency 1); holds otherwise.
REQ-024 readdata bits [31:WIDTH] always 0; reserved address returns 32'h0.
REQ-025 Simultaneous read and write of same register in one cycle: readdata returns pre-write value.
REQ-026 Arming counter: edge detection disabled for SYNC_STAGES+1 cycles after reset deasserts, so reset-time input levels never produce spurious captures.

Reset
REQ-027 While reset high at a clock edge: sync chain, data, prev, irqmask, edgecapture, readdata cleared to 0; arming counter restarted; irq 0 next cycle.
REQ-028 Reset asserted mid-operation discards all pending captures and in-flight synchronizer values; no partial state survives.

Verification
REQ-029 Rising capture: EDGE_TYPE=0, armed, irqmask=1; in_port bit0 0->1 -> edgecapture=1 and irq=1 exactly SYNC_STAGES+1 edges later; read addr 3 -> 32'h1.
REQ-030 Clear: edgecapture=0x5; write addr 3 data 0x1 -> edgecapture=0x4; irq follows mask 0x4.
REQ-031 Clear collision: write addr 3 data 0x1 same cycle as new bit0 rising edge -> bit0 stays 1, irq stays high.
REQ-032 Reset with in_port=25'h1FFFFFF held high -> after deassert and arming, edgecapture=0, irq=0; data read = 32'h01FFFFFF.
REQ-033 Mask: edgecapture=0x2, irqmask=0x1 -> irq=0; write irqmask 0x2 -> irq=1 next cycle; read addr 1 -> 32'h0.
REQ-034 EDGE_TYPE=2: bit3 toggles 0->1->0 with clear between -> capture set on both transitions.
